led_matrix_scanner: RTL and testbench
=====================================

LED_MATRIX_SCANNER -- requirements
Module: led_matrix_scanner

Interface
REQ-001 Parameter ROWS, default 8: number of matrix rows scanned, at least 2.
REQ-002 Parameter COLS, default 8: number of column lines per row, at least 1.
REQ-003 Parameter DIV, default 1000: system_clk cycles per row slot, at least 2.
REQ-004 Parameter PWM_BITS, default 4: brightness resolution in bits, at least 1.
REQ-005 system_clk  input  1  sole clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  scan enable; when low, the display is blanked and the scan is frozen.
REQ-008 brightness  input  PWM_BITS  global brightness level; 0 means dark.
REQ-009 fb_data  input  ROWS*COLS  new frame; row r occupies bits [r*COLS +: COLS].
REQ-010 fb_load  input  1  one-cycle strobe that requests capture of fb_data.
REQ-011 fb_ack  output  1  one-cycle pulse confirming the capture.
REQ-012 row  output  ROWS  one-hot row drive, active-high.
REQ-013 col  output  COLS  column data for the driven row, active-high.
REQ-014 frame_start  output  1  one-cycle pulse at the start of row 0 of each frame.

Function
REQ-015 The block SHALL keep a slot counter cnt, counting 0..DIV-1, which increments every cycle while enable=1 and wraps to 0.
REQ-016 The block SHALL keep a row index idx, counting 0..ROWS-1, which advances when cnt=DIV-1 and enable=1, wrapping from ROWS-1 to 0.
REQ-017 While enable=0, cnt and idx SHALL hold their values and row/col SHALL be 0 from the next edge.
REQ-018 On-time SHALL be ON = (brightness*DIV) >> PWM_BITS, computed at full width with no overflow, sampled every cycle.
REQ-019 row SHALL be registered as (1<<idx) when enable=1 and cnt<ON, else 0; latency is one cycle from the cnt/idx state.
REQ-020 col SHALL be registered as disp[idx*COLS +: COLS] under the same condition, else 0; col is never non-zero while row=0.
REQ-021 fb_load=1 SHALL copy fb_data into the shadow buffer, set pending, and pulse fb_ack on the next cycle; back-to-back loads are each acknowledged, and the last one wins.
REQ-022 At a frame boundary (cnt=DIV-1, idx=ROWS-1, enable=1) with pending=1, the display buffer disp SHALL take the shadow contents and pending SHALL clear; the display never changes mid-frame.
REQ-023 If fb_load coincides with a frame boundary, disp SHALL take the pre-existing shadow and the new data SHALL go to shadow with pending=1, to be displayed at the following boundary.
REQ-024 frame_start SHALL be registered high for exactly one cycle, in the same cycle row first shows idx 0 after a wrap; it does not fire when leaving reset.
REQ-025 fb_load and the capture path SHALL operate regardless of enable.

Reset
REQ-026 rst=1 SHALL immediately force cnt=0, idx=0, disp=0, shadow=0, pending=0, row=0, col=0, fb_ack=0 and frame_start=0.
REQ-027 After rst deasserts, scanning SHALL begin at idx 0, cnt 0 on the first edge; a reset mid-frame discards the pending frame.

Verification
(ROWS=8, COLS=8, DIV=4, PWM_BITS=2, so ON=brightness.)
REQ-028 Scan order: enable=1, brightness=3, frame loaded with row r = r+1 -> row = 01,02,...,80 then back to 01, each asserted for 3 of every 4 cycles; col = 01..08 on the matching rows; frame_start every 32 cycles.
REQ-029 PWM extremes: brightness=0 -> row=col=0 for the whole frame; brightness=1 -> exactly 1 active cycle per slot.
REQ-030 Double buffer: fb_load mid-frame with all rows = FF -> fb_ack one cycle later; col keeps the old data until the first frame_start, then shows FF.
REQ-031 Boundary collision: fb_load (value AA) at cnt=3, idx=7 while shadow holds 55 and pending=1 -> the next frame shows 55 and the frame after shows AA.
REQ-032 Enable hold: drop enable at idx=3, cnt=2 for 10 cycles -> row/col 0 throughout; on resume, idx 3 continues at cnt 2.
REQ-033 Async reset: assert rst between clock edges mid-frame -> all outputs 0 before the next edge; after release, row 01 appears after one cycle with disp=0, so col=00.

Source files
------------

// File: rtl/led_matrix_scanner_if.sv
// rtl/led_matrix_scanner_if.sv - frame buffer load handshake between host and scanner
interface led_matrix_scanner_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    logic [ROWS*COLS-1:0] fb_data;
    logic                 fb_load;
    logic                 fb_ack;

    modport master (output fb_data, output fb_load, input fb_ack);
    modport slave  (input fb_data, input fb_load, output fb_ack);
endinterface

// File: rtl/led_matrix_scanner.sv
// rtl/led_matrix_scanner.sv - row-scanned LED matrix driver with PWM dimming and double-buffered frames
module led_matrix_scanner #(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int DIV      = 1000,
    parameter int PWM_BITS = 4
) (
    input  logic                system_clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [PWM_BITS-1:0] brightness,
    led_matrix_scanner_if.slave fb,
    output logic [ROWS-1:0]     row,
    output logic [COLS-1:0]     col,
    output logic                frame_start
);
    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = $clog2(ROWS);
    // Wide enough to hold brightness*DIV without overflow.
    localparam int ON_W  = PWM_BITS + $clog2(DIV + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(ROWS - 1);

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [ROWS*COLS-1:0] disp_q, disp_d;
    logic [ROWS*COLS-1:0] shadow_q, shadow_d;
    logic                 pending_q, pending_d;
    // Set when the scan wraps to row 0; consumed by the next frame_start.
    logic                 wrap_q, wrap_d;
    logic                 fb_ack_q, fb_ack_d;
    logic [ROWS-1:0]      row_q, row_d;
    logic [COLS-1:0]      col_q, col_d;
    logic                 frame_start_q, frame_start_d;

    logic [ON_W-1:0]      on_time;
    logic                 slot_end;
    logic                 frame_end;
    logic                 lit;
    logic                 fs_hit;

    assign on_time   = (ON_W'(brightness) * ON_W'(DIV)) >> PWM_BITS;
    assign slot_end  = enable && (cnt_q == CNT_MAX);
    assign frame_end = slot_end && (idx_q == IDX_MAX);
    assign lit       = enable && (ON_W'(cnt_q) < on_time);
    assign fs_hit    = enable && (cnt_q == '0) && (idx_q == '0) && wrap_q;

    // Next-state: scan position, frame buffers and registered display outputs.
    always_comb begin
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        disp_d        = disp_q;
        shadow_d      = shadow_q;
        pending_d     = pending_q;
        wrap_d        = wrap_q;
        fb_ack_d      = fb.fb_load;
        row_d         = '0;
        col_d         = '0;
        frame_start_d = fs_hit;

        if (enable) begin
            cnt_d = slot_end ? '0 : cnt_q + 1'b1;
            if (slot_end) begin
                idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
            end
        end

        // Swap uses the old shadow; a coincident load lands in shadow afterwards.
        if (frame_end && pending_q) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
        end
        if (fb.fb_load) begin
            shadow_d  = fb.fb_data;
            pending_d = 1'b1;
        end

        if (frame_end) begin
            wrap_d = 1'b1;
        end else if (fs_hit) begin
            wrap_d = 1'b0;
        end

        if (lit) begin
            row_d = ROWS'(1) << idx_q;
            col_d = disp_q[idx_q*COLS +: COLS];
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge system_clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            disp_q        <= '0;
            shadow_q      <= '0;
            pending_q     <= 1'b0;
            wrap_q        <= 1'b0;
            fb_ack_q      <= 1'b0;
            row_q         <= '0;
            col_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            disp_q        <= disp_d;
            shadow_q      <= shadow_d;
            pending_q     <= pending_d;
            wrap_q        <= wrap_d;
            fb_ack_q      <= fb_ack_d;
            row_q         <= row_d;
            col_q         <= col_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign row         = row_q;
    assign col         = col_q;
    assign frame_start = frame_start_q;
    assign fb.fb_ack   = fb_ack_q;
endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb/tb_led_matrix_scanner.sv - self-checking bench for led_matrix_scanner
module tb_led_matrix_scanner;
    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int DIV = 4;
    localparam int PWM_BITS = 2;
    localparam int FRAME = ROWS * DIV;

    logic                system_clk = 1'b0;
    logic                rst = 1'b1;
    logic                enable = 1'b0;
    logic [PWM_BITS-1:0] brightness = '0;
    logic [ROWS-1:0]     row;
    logic [COLS-1:0]     col;
    logic                frame_start;

    led_matrix_scanner_if #(.ROWS(ROWS), .COLS(COLS)) fb_if ();

    led_matrix_scanner #(.ROWS(ROWS), .COLS(COLS), .DIV(DIV), .PWM_BITS(PWM_BITS)) dut (
        .system_clk  (system_clk),
        .rst         (rst),
        .enable      (enable),
        .brightness  (brightness),
        .fb          (fb_if),
        .row         (row),
        .col         (col),
        .frame_start (frame_start)
    );

    always #5 system_clk = ~system_clk;

    typedef struct packed {
        logic [ROWS-1:0] row;
        logic [COLS-1:0] col;
        logic            fs;
        logic            ack;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference: pos counts enabled cycles since reset, so cnt = pos % DIV, idx = (pos / DIV) % ROWS.
    int                   pos;
    logic [ROWS*COLS-1:0] m_disp;
    logic [ROWS*COLS-1:0] m_shadow;
    logic                 m_pending;

    function automatic logic [ROWS*COLS-1:0] fill(input logic [COLS-1:0] v);
        logic [ROWS*COLS-1:0] f;
        for (int r = 0; r < ROWS; r++) f[r*COLS +: COLS] = v;
        return f;
    endfunction

    // Applies one cycle of stimulus at a negedge, queues the output expected after the next edge.
    task automatic drive(input logic en, input logic [PWM_BITS-1:0] br, input logic ld,
                         input logic [ROWS*COLS-1:0] data);
        exp_t e;
        int c, r, on;
        enable = en;
        brightness = br;
        fb_if.fb_load = ld;
        fb_if.fb_data = data;
        c = pos % DIV;
        r = (pos / DIV) % ROWS;
        on = (int'(br) * DIV) >> PWM_BITS;
        e.row = (en && c < on) ? ROWS'(1 << r) : '0;
        e.col = (en && c < on) ? m_disp[r*COLS +: COLS] : '0;
        e.fs  = en && (c == 0) && (r == 0) && (pos > 0);
        e.ack = ld;
        exp_q.push_back(e);
        if (en && (pos % FRAME) == FRAME - 1 && m_pending) begin
            m_disp = m_shadow;
            m_pending = 1'b0;
        end
        if (ld) begin
            m_shadow = data;
            m_pending = 1'b1;
        end
        if (en) pos++;
        @(posedge system_clk);
        @(negedge system_clk);
    endtask

    task automatic model_clear();
        pos = 0;
        m_disp = '0;
        m_shadow = '0;
        m_pending = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b0;
        fb_if.fb_load = 1'b0;
        fb_if.fb_data = '0;
        model_clear();
        repeat (2) @(negedge system_clk);
        checks++;
        if (row !== 8'h00) begin errors++; $display("FAIL reset_row got %h want 00", row); end
        checks++;
        if (col !== 8'h00) begin errors++; $display("FAIL reset_col got %h want 00", col); end
        checks++;
        if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got %b want 0", frame_start); end
        checks++;
        if (fb_if.fb_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", fb_if.fb_ack); end
        rst = 1'b0;
    endtask

    task automatic test_scan();
        exp_t e;
        logic [ROWS*COLS-1:0] f;
        int fs_cnt = 0;
        int active = 0;
        for (int r = 0; r < ROWS; r++) f[r*COLS +: COLS] = COLS'(r + 1);
        drive(1'b0, 2'd3, 1'b1, f);
        e = exp_q.pop_front();
        checks++;
        if (row !== e.row || col !== e.col || frame_start !== e.fs || fb_if.fb_ack !== e.ack) begin
            errors++;
            $display("FAIL scan_load row %h/%h col %h/%h fs %b/%b ack %b/%b", row, e.row, col, e.col, frame_start, e.fs, fb_if.fb_ack, e.ack);
        end
        for (int i = 0; i < 72; i++) begin
            drive(1'b1, 2'd3, 1'b0, f);
            e = exp_q.pop_front();
            checks++;
            if (row !== e.row || col !== e.col || frame_start !== e.fs || fb_if.fb_ack !== e.ack) begin
                errors++;
                $display("FAIL scan cyc %0d row %h/%h col %h/%h fs %b/%b ack %b/%b", i, row, e.row, col, e.col, frame_start, e.fs, fb_if.fb_ack, e.ack);
            end
            if (frame_start === 1'b1) fs_cnt++;
            if (row !== 8'h00) active++;
        end
        checks++;
        if (fs_cnt != 2) begin errors++; $display("FAIL scan_fs_count got %0d want 2", fs_cnt); end
        checks++;
        if (active != 54) begin errors++; $display("FAIL scan_active got %0d want 54", active); end
    endtask

    task automatic test_pwm();
        exp_t e;
        int active;
        for (int b = 0; b < 2; b++) begin
            active = 0;
            for (int i = 0; i < FRAME; i++) begin
                drive(1'b1, PWM_BITS'(b), 1'b0, '0);
                e = exp_q.pop_front();
                checks++;
                if (row !== e.row || col !== e.col || frame_start !== e.fs || fb_if.fb_ack !== e.ack) begin
                    errors++;
                    $display("FAIL pwm br %0d cyc %0d row %h/%h col %h/%h fs %b/%b", b, i, row, e.row, col, e.col, frame_start, e.fs);
                end
                if (row !== 8'h00) active++;
            end
            checks++;
            if (active != b * ROWS) begin errors++; $display("FAIL pwm_active br %0d got %0d want %0d", b, active, b * ROWS); end
        end
    endtask

    task automatic test_double_buffer();
        exp_t e;
        logic got_fs = 1'b0;
        drive(1'b1, 2'd3, 1'b1, fill(8'hFF));
        e = exp_q.pop_front();
        checks++;
        if (fb_if.fb_ack !== 1'b1 || row !== e.row || col !== e.col) begin
            errors++;
            $display("FAIL dbuf_ack ack %b/1 row %h/%h col %h/%h", fb_if.fb_ack, row, e.row, col, e.col);
        end
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 2'd3, 1'b0, '0);
            e = exp_q.pop_front();
            if (frame_start === 1'b1) got_fs = 1'b1;
            checks++;
            if (row !== e.row || col !== e.col || frame_start !== e.fs || fb_if.fb_ack !== e.ack ||
                (row !== 8'h00 && ((col === 8'hFF) != got_fs))) begin
                errors++;
                $display("FAIL dbuf cyc %0d row %h/%h col %h/%h fs %b/%b seen_fs %b", i, row, e.row, col, e.col, frame_start, e.fs, got_fs);
            end
        end
        checks++;
        if (!got_fs) begin errors++; $display("FAIL dbuf_fs_timeout got none want frame_start"); end
    endtask

    task automatic test_collision();
        exp_t e;
        logic [COLS-1:0] seen[2];
        int n = 0;
        int guard = 0;
        while ((pos % FRAME) != 10 && guard < 2 * FRAME) begin
            drive(1'b1, 2'd3, 1'b0, '0);
            e = exp_q.pop_front();
            guard++;
            checks++;
            if (row !== e.row || col !== e.col || frame_start !== e.fs) begin
                errors++;
                $display("FAIL coll_pre row %h/%h col %h/%h fs %b/%b", row, e.row, col, e.col, frame_start, e.fs);
            end
        end
        for (int i = 0; i < FRAME - 10; i++) begin
            drive(1'b1, 2'd3, (i == 0 || i == FRAME - 11), (i == 0) ? fill(8'h55) : fill(8'hAA));
            e = exp_q.pop_front();
            checks++;
            if (row !== e.row || col !== e.col || frame_start !== e.fs || fb_if.fb_ack !== e.ack) begin
                errors++;
                $display("FAIL coll_load cyc %0d row %h/%h col %h/%h fs %b/%b ack %b/%b", i, row, e.row, col, e.col, frame_start, e.fs, fb_if.fb_ack, e.ack);
            end
        end
        seen[0] = '0;
        seen[1] = '0;
        for (int i = 0; i < 2 * FRAME + 2; i++) begin
            drive(1'b1, 2'd3, 1'b0, '0);
            e = exp_q.pop_front();
            checks++;
            if (row !== e.row || col !== e.col || frame_start !== e.fs || fb_if.fb_ack !== e.ack) begin
                errors++;
                $display("FAIL coll cyc %0d row %h/%h col %h/%h fs %b/%b", i, row, e.row, col, e.col, frame_start, e.fs);
            end
            if (frame_start === 1'b1 && n < 2) begin
                seen[n] = col;
                n++;
            end
        end
        checks++;
        if (seen[0] !== 8'h55) begin errors++; $display("FAIL coll_frame1 got %h want 55", seen[0]); end
        checks++;
        if (seen[1] !== 8'hAA) begin errors++; $display("FAIL coll_frame2 got %h want AA", seen[1]); end
    endtask

    task automatic test_enable_hold();
        exp_t e;
        int guard = 0;
        logic [ROWS-1:0] want;
        while ((pos % FRAME) != 14 && guard < 2 * FRAME) begin
            drive(1'b1, 2'd3, 1'b0, '0);
            e = exp_q.pop_front();
            guard++;
            checks++;
            if (row !== e.row || col !== e.col || frame_start !== e.fs) begin
                errors++;
                $display("FAIL hold_pre row %h/%h col %h/%h fs %b/%b", row, e.row, col, e.col, frame_start, e.fs);
            end
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 2'd3, 1'b0, '0);
            e = exp_q.pop_front();
            checks++;
            if (row !== 8'h00 || col !== 8'h00 || row !== e.row || col !== e.col || frame_start !== e.fs) begin
                errors++;
                $display("FAIL hold cyc %0d row %h/00 col %h/00 fs %b/%b", i, row, col, frame_start, e.fs);
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd3, 1'b0, '0);
            e = exp_q.pop_front();
            want = (i == 0) ? 8'h08 : ((i == 1) ? 8'h00 : 8'h10);
            checks++;
            if (row !== want || row !== e.row || col !== e.col || frame_start !== e.fs) begin
                errors++;
                $display("FAIL hold_resume cyc %0d row %h want %h col %h/%h", i, row, want, col, e.col);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd3, (i == 0), fill(8'hBB));
            e = exp_q.pop_front();
            checks++;
            if (row !== e.row || col !== e.col || frame_start !== e.fs || fb_if.fb_ack !== e.ack) begin
                errors++;
                $display("FAIL arst_pre cyc %0d row %h/%h col %h/%h ack %b/%b", i, row, e.row, col, e.col, fb_if.fb_ack, e.ack);
            end
        end
        @(posedge system_clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (row !== 8'h00 || col !== 8'h00 || frame_start !== 1'b0 || fb_if.fb_ack !== 1'b0) begin
            errors++;
            $display("FAIL arst_immediate row %h col %h fs %b ack %b want all 0", row, col, frame_start, fb_if.fb_ack);
        end
        @(negedge system_clk);
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < FRAME + 4; i++) begin
            drive(1'b1, 2'd3, 1'b0, '0);
            e = exp_q.pop_front();
            checks++;
            if (row !== e.row || col !== e.col || frame_start !== e.fs || fb_if.fb_ack !== e.ack ||
                (i == 0 && (row !== 8'h01 || col !== 8'h00))) begin
                errors++;
                $display("FAIL arst_post cyc %0d row %h/%h col %h/%h fs %b/%b", i, row, e.row, col, e.col, frame_start, e.fs);
            end
        end
    endtask

    initial begin
        fb_if.fb_load = 1'b0;
        fb_if.fb_data = '0;
        test_reset();
        test_scan();
        test_pwm();
        test_double_buffer();
        test_collision();
        test_enable_hold();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
